// File: rtl/regfile_write_arbiter.sv
// Single write port arbiter for the 16x16 register file: load returns take priority,
// and ALU results are queued in a small FIFO. The optional macro WB_BYPASS_EN lets an ALU result skip an empty FIFO.
module regfile_write_arbiter #(
   parameter int DEPTH         = 2,
   parameter bit ZERO_REG_DROP = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        alu_valid,
   input  logic [3:0]  alu_reg,
   input  logic [15:0] alu_data,
   output logic        alu_ready,
   input  logic        ld_valid,
   input  logic [3:0]  ld_reg,
   input  logic [15:0] ld_data,
   output logic [3:0]  DstReg,
   output logic        WriteReg,
   output logic [15:0] DstData,
   output logic [15:0] pending_mask,
   output logic [2:0]  fifo_count
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

   logic [3:0]       q_reg  [DEPTH];
   logic [15:0]      q_data [DEPTH];
   logic [DEPTH-1:0] q_vld;
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic [CW-1:0]    count;

   logic ld_take;
   logic alu_keep;
   logic push;
   logic pop;
   logic enq;
   logic bypass;
   logic empty;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      if (p == LAST_C) ptr_next = '0;
      else             ptr_next = p + 1'b1;
   endfunction

   // A load to R0 in drop mode is not a write, so it must not block a FIFO pop.
   always_comb begin
      ld_take   = ld_valid & ~(ZERO_REG_DROP && (ld_reg == 4'd0));
      alu_ready = (count < DEPTH_C) & ~rst;
      push      = alu_valid & alu_ready;
      alu_keep  = push & ~(ZERO_REG_DROP && (alu_reg == 4'd0));
      empty     = (count == '0);
      pop       = ~ld_take & ~empty;
`ifdef WB_BYPASS_EN
      bypass    = alu_keep & ~ld_take & empty;
`else
      bypass    = 1'b0;
`endif
      enq       = alu_keep & ~bypass;
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         q_reg[wr_ptr]  <= alu_reg;
         q_data[wr_ptr] <= alu_data;
      end
   end

   // Push and pop never address the same slot: push needs a free slot, pop a full one.
   always_ff @(posedge clk) begin
      if (rst) begin
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         q_vld    <= '0;
         WriteReg <= 1'b0;
         DstReg   <= 4'd0;
         DstData  <= 16'd0;
      end else begin
         if (pop) begin
            rd_ptr        <= ptr_next(rd_ptr);
            q_vld[rd_ptr] <= 1'b0;
         end
         if (enq) begin
            wr_ptr        <= ptr_next(wr_ptr);
            q_vld[wr_ptr] <= 1'b1;
         end
         case ({enq, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (ld_take) begin
            WriteReg <= 1'b1;
            DstReg   <= ld_reg;
            DstData  <= ld_data;
         end else if (pop) begin
            WriteReg <= 1'b1;
            DstReg   <= q_reg[rd_ptr];
            DstData  <= q_data[rd_ptr];
         end else if (bypass) begin
            WriteReg <= 1'b1;
            DstReg   <= alu_reg;
            DstData  <= alu_data;
         end else begin
            WriteReg <= 1'b0;
         end
      end
   end

   always_comb begin
      pending_mask = 16'd0;
      for (int i = 0; i < DEPTH; i++) begin
         if (q_vld[i]) pending_mask[q_reg[i]] = 1'b1;
      end
      if (WriteReg) pending_mask[DstReg] = 1'b1;
   end

   assign fifo_count = 3'(count);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter (default build): a vector table for
// reset, lone write, collision, backpressure and R0 loads, then wrap and mid-reset sequences.
module tb_regfile_write_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid;
   logic [3:0]  alu_reg;
   logic [15:0] alu_data;
   logic        alu_ready;
   logic        ld_valid;
   logic [3:0]  ld_reg;
   logic [15:0] ld_data;
   logic [3:0]  DstReg;
   logic        WriteReg;
   logic [15:0] DstData;
   logic [15:0] pending_mask;
   logic [2:0]  fifo_count;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [19:0] exp_q[$];

   always #5 clk = ~clk;

   regfile_write_arbiter #(.DEPTH(2), .ZERO_REG_DROP(1'b1)) dut (
      .clk          (clk),
      .rst          (rst),
      .alu_valid    (alu_valid),
      .alu_reg      (alu_reg),
      .alu_data     (alu_data),
      .alu_ready    (alu_ready),
      .ld_valid     (ld_valid),
      .ld_reg       (ld_reg),
      .ld_data      (ld_data),
      .DstReg       (DstReg),
      .WriteReg     (WriteReg),
      .DstData      (DstData),
      .pending_mask (pending_mask),
      .fifo_count   (fifo_count)
   );

   typedef struct {
      logic        r;
      logic        av;
      logic [3:0]  ar;
      logic [15:0] ad;
      logic        lv;
      logic [3:0]  lr;
      logic [15:0] ld;
      logic        e_rdy;
      logic        e_we;
      logic [3:0]  e_reg;
      logic [15:0] e_data;
      logic [15:0] e_mask;
      logic [2:0]  e_cnt;
   } vec_t;

   vec_t vecs[23];

   function automatic vec_t mk(input logic r, input logic av, input logic [3:0] ar,
                               input logic [15:0] ad, input logic lv, input logic [3:0] lr,
                               input logic [15:0] ld, input logic e_rdy, input logic e_we,
                               input logic [3:0] e_reg, input logic [15:0] e_data,
                               input logic [15:0] e_mask, input logic [2:0] e_cnt);
      vec_t v;
      v.r = r; v.av = av; v.ar = ar; v.ad = ad; v.lv = lv; v.lr = lr; v.ld = ld;
      v.e_rdy = e_rdy; v.e_we = e_we; v.e_reg = e_reg; v.e_data = e_data;
      v.e_mask = e_mask; v.e_cnt = e_cnt;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic r, input logic av, input logic [3:0] ar, input logic [15:0] ad,
                        input logic lv, input logic [3:0] lr, input logic [15:0] ld);
      rst = r; alu_valid = av; alu_reg = ar; alu_data = ad;
      ld_valid = lv; ld_reg = lr; ld_data = ld;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int writes;
      logic [19:0] e;
      drive(1'b1, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);

      // reset / lone ALU write / collision
      vecs[0]  = mk(1, 1, 4'h9, 16'h5555, 0, 4'h0, 16'h0000, 0, 0, 4'h0, 16'h0000, 16'h0000, 3'd0);
      vecs[1]  = mk(1, 1, 4'h9, 16'h5555, 0, 4'h0, 16'h0000, 0, 0, 4'h0, 16'h0000, 16'h0000, 3'd0);
      vecs[2]  = mk(0, 0, 4'h0, 16'h0000, 0, 4'h0, 16'h0000, 1, 0, 4'h0, 16'h0000, 16'h0000, 3'd0);
      vecs[3]  = mk(0, 1, 4'h3, 16'h1234, 0, 4'h0, 16'h0000, 1, 0, 4'h0, 16'h0000, 16'h0008, 3'd1);
      vecs[4]  = mk(0, 0, 4'h0, 16'h0000, 0, 4'h0, 16'h0000, 1, 1, 4'h3, 16'h1234, 16'h0008, 3'd0);
      vecs[5]  = mk(0, 0, 4'h0, 16'h0000, 0, 4'h0, 16'h0000, 1, 0, 4'h3, 16'h1234, 16'h0000, 3'd0);
      vecs[6]  = mk(0, 1, 4'h6, 16'h0042, 1, 4'h5, 16'hBEEF, 1, 1, 4'h5, 16'hBEEF, 16'h0060, 3'd1);
      vecs[7]  = mk(0, 0, 4'h0, 16'h0000, 0, 4'h0, 16'h0000, 1, 1, 4'h6, 16'h0042, 16'h0040, 3'd0);
      vecs[8]  = mk(0, 0, 4'h0, 16'h0000, 0, 4'h0, 16'h0000, 1, 0, 4'h6, 16'h0042, 16'h0000, 3'd0);
      // backpressure: loads stream while the FIFO fills
      vecs[9]  = mk(0, 1, 4'h1, 16'h0011, 1, 4'h8, 16'hA008, 1, 1, 4'h8, 16'hA008, 16'h0102, 3'd1);
      vecs[10] = mk(0, 1, 4'h2, 16'h0022, 1, 4'h9, 16'hA009, 1, 1, 4'h9, 16'hA009, 16'h0206, 3'd2);
      vecs[11] = mk(0, 1, 4'h3, 16'h0033, 1, 4'hA, 16'hA00A, 0, 1, 4'hA, 16'hA00A, 16'h0406, 3'd2);
      vecs[12] = mk(0, 1, 4'h3, 16'h0033, 1, 4'hB, 16'hA00B, 0, 1, 4'hB, 16'hA00B, 16'h0806, 3'd2);
      vecs[13] = mk(0, 1, 4'h3, 16'h0033, 0, 4'h0, 16'h0000, 0, 1, 4'h1, 16'h0011, 16'h0006, 3'd1);
      vecs[14] = mk(0, 1, 4'h3, 16'h0033, 0, 4'h0, 16'h0000, 1, 1, 4'h2, 16'h0022, 16'h000C, 3'd1);
      vecs[15] = mk(0, 1, 4'h4, 16'h0044, 0, 4'h0, 16'h0000, 1, 1, 4'h3, 16'h0033, 16'h0018, 3'd1);
      vecs[16] = mk(0, 0, 4'h0, 16'h0000, 0, 4'h0, 16'h0000, 1, 1, 4'h4, 16'h0044, 16'h0010, 3'd0);
      vecs[17] = mk(0, 0, 4'h0, 16'h0000, 0, 4'h0, 16'h0000, 1, 0, 4'h4, 16'h0044, 16'h0000, 3'd0);
      // R0 loads and pushes are dropped; an R0 load does not block a pop
      vecs[18] = mk(0, 0, 4'h0, 16'h0000, 1, 4'h0, 16'hDEAD, 1, 0, 4'h4, 16'h0044, 16'h0000, 3'd0);
      vecs[19] = mk(0, 1, 4'h0, 16'h0077, 1, 4'h0, 16'hDEAD, 1, 0, 4'h4, 16'h0044, 16'h0000, 3'd0);
      vecs[20] = mk(0, 1, 4'hC, 16'h00CC, 0, 4'h0, 16'h0000, 1, 0, 4'h4, 16'h0044, 16'h1000, 3'd1);
      vecs[21] = mk(0, 0, 4'h0, 16'h0000, 1, 4'h0, 16'hDEAD, 1, 1, 4'hC, 16'h00CC, 16'h1000, 3'd0);
      vecs[22] = mk(0, 0, 4'h0, 16'h0000, 0, 4'h0, 16'h0000, 1, 0, 4'hC, 16'h00CC, 16'h0000, 3'd0);

      tick();
      for (int i = 0; i < 23; i++) begin
         drive(vecs[i].r, vecs[i].av, vecs[i].ar, vecs[i].ad, vecs[i].lv, vecs[i].lr, vecs[i].ld);
         #3;
         check($sformatf("v%0d alu_ready", i), 32'(alu_ready), 32'(vecs[i].e_rdy));
         tick();
         check($sformatf("v%0d WriteReg", i), 32'(WriteReg), 32'(vecs[i].e_we));
         check($sformatf("v%0d DstReg", i), 32'(DstReg), 32'(vecs[i].e_reg));
         check($sformatf("v%0d DstData", i), 32'(DstData), 32'(vecs[i].e_data));
         check($sformatf("v%0d pending_mask", i), 32'(pending_mask), 32'(vecs[i].e_mask));
         check($sformatf("v%0d fifo_count", i), 32'(fifo_count), 32'(vecs[i].e_cnt));
      end

      // wrap: alternate R0/R7 pushes, only odd-data R7 writes may appear
      writes = 0;
      for (int i = 0; i < 16; i++) begin
         if (i < 10) drive(1'b0, 1'b1, (i % 2 == 1) ? 4'd7 : 4'd0, 16'(i), 1'b0, 4'd0, 16'd0);
         else        drive(1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
         #3;
         if (alu_valid && alu_ready && alu_reg != 4'd0) exp_q.push_back({alu_reg, alu_data});
         if (alu_valid) check("wrap alu_ready", 32'(alu_ready), 32'd1);
         tick();
         check("wrap fifo_count bound", 32'(fifo_count <= 3'd2), 32'd1);
         if (WriteReg) begin
            writes++;
            if (exp_q.size() == 0) begin
               check("wrap unexpected write", {12'd0, DstReg, DstData}, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("wrap write", {12'd0, DstReg, DstData}, {12'd0, e});
            end
         end
      end
      check("wrap write count", 32'(writes), 32'd5);
      check("wrap queue drained", 32'(exp_q.size()), 32'd0);

      // reset with two queued entries: neither may ever be written
      drive(1'b0, 1'b1, 4'd9, 16'h0099, 1'b1, 4'd1, 16'h1111);
      tick();
      drive(1'b0, 1'b1, 4'd10, 16'h00AA, 1'b1, 4'd1, 16'h1112);
      tick();
      check("midrst fifo_count full", 32'(fifo_count), 32'd2);
      check("midrst pending", 32'(pending_mask), 32'h0000_0602);
      drive(1'b1, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
      #3;
      check("midrst alu_ready in reset", 32'(alu_ready), 32'd0);
      tick();
      check("midrst fifo_count", 32'(fifo_count), 32'd0);
      check("midrst WriteReg", 32'(WriteReg), 32'd0);
      check("midrst pending", 32'(pending_mask), 32'd0);
      drive(1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("midrst no stale write", 32'(WriteReg), 32'd0);
         check("midrst count stays 0", 32'(fifo_count), 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
